// File: rtl/saturn_bus_pc_loader.sv
// Serializes a PC reload onto the Saturn nibble bus as LOAD_PC, five address
// nibbles (LSB first) and PC_READ, holding the core's bus-busy while in flight.
module saturn_bus_pc_loader #(
  parameter logic [3:0] CMD_LOAD_PC = 4'h4,
  parameter logic [3:0] CMD_PC_READ = 4'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic [3:0]  i_phases,
  input  logic        i_load_pc,
  input  logic [19:0] i_pc,
  input  logic        i_bus_ready,
  output logic [3:0]  o_bus_nibble,
  output logic        o_bus_strobe,
  output logic        o_bus_is_cmd,
  output logic        o_busy,
  output logic        o_done,
  output logic [19:0] o_loaded_pc
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_ADDR, S_READ} state_t;

  state_t      state_q, state_d;
  logic [2:0]  nib_ctr_q, nib_ctr_d;
  logic [19:0] pc_buf_q, pc_buf_d;
  logic        pending_q, pending_d;
  logic [19:0] pending_pc_q, pending_pc_d;
  logic [3:0]  nibble_q, nibble_d;
  logic        strobe_q, strobe_d;
  logic        is_cmd_q, is_cmd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [19:0] loaded_pc_q, loaded_pc_d;

  logic        accept_slot;
  logic        emit_slot;
  logic [3:0]  addr_nib;
  logic        unused_phases;

  assign accept_slot   = i_clk_en & i_phases[3];
  assign emit_slot     = i_clk_en & i_phases[0] & i_bus_ready;
  assign unused_phases = ^i_phases[2:1];

  always_comb begin
    case (nib_ctr_q)
      3'd0:    addr_nib = pc_buf_q[3:0];
      3'd1:    addr_nib = pc_buf_q[7:4];
      3'd2:    addr_nib = pc_buf_q[11:8];
      3'd3:    addr_nib = pc_buf_q[15:12];
      default: addr_nib = pc_buf_q[19:16];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    nib_ctr_d    = nib_ctr_q;
    pc_buf_d     = pc_buf_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    nibble_d     = nibble_q;
    is_cmd_d     = is_cmd_q;
    loaded_pc_d  = loaded_pc_q;
    // Strobe and done are single-clock pulses regardless of the clock enable.
    strobe_d     = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_slot && i_load_pc) begin
          pc_buf_d  = i_pc;
          nib_ctr_d = 3'd0;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (emit_slot) begin
          nibble_d = CMD_LOAD_PC;
          is_cmd_d = 1'b1;
          strobe_d = 1'b1;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (emit_slot) begin
          nibble_d = addr_nib;
          is_cmd_d = 1'b0;
          strobe_d = 1'b1;
          if (nib_ctr_q == 3'd4) begin
            nib_ctr_d = 3'd0;
            state_d   = S_READ;
          end else begin
            nib_ctr_d = nib_ctr_q + 3'd1;
          end
        end
      end
      S_READ: begin
        if (emit_slot) begin
          nibble_d    = CMD_PC_READ;
          is_cmd_d    = 1'b1;
          strobe_d    = 1'b1;
          done_d      = 1'b1;
          loaded_pc_d = pc_buf_q;
          // A request that arrived mid-sequence chains straight on.
          if (pending_q) begin
            pc_buf_d  = pending_pc_q;
            pending_d = 1'b0;
            nib_ctr_d = 3'd0;
            state_d   = S_CMD;
          end else begin
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && accept_slot && i_load_pc) begin
      pending_d    = 1'b1;
      pending_pc_d = i_pc;
    end

    busy_d = (state_d != S_IDLE) | done_d;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      nib_ctr_q    <= 3'd0;
      pc_buf_q     <= 20'h00000;
      pending_q    <= 1'b0;
      pending_pc_q <= 20'h00000;
      nibble_q     <= 4'h0;
      strobe_q     <= 1'b0;
      is_cmd_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      loaded_pc_q  <= 20'h00000;
    end else begin
      state_q      <= state_d;
      nib_ctr_q    <= nib_ctr_d;
      pc_buf_q     <= pc_buf_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      nibble_q     <= nibble_d;
      strobe_q     <= strobe_d;
      is_cmd_q     <= is_cmd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      loaded_pc_q  <= loaded_pc_d;
    end
  end

  assign o_bus_nibble = nibble_q;
  assign o_bus_strobe = strobe_q;
  assign o_bus_is_cmd = is_cmd_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_loaded_pc  = loaded_pc_q;

endmodule

// File: tb/tb_saturn_bus_pc_loader.sv
// Bench for saturn_bus_pc_loader: vector table, hand-written corner sequences
// and randomized traffic checked every clock against a transaction-level model.
module tb_saturn_bus_pc_loader;

  logic        clk;
  logic        rst_n;
  logic        i_clk_en;
  logic [3:0]  i_phases;
  logic        i_load_pc;
  logic [19:0] i_pc;
  logic        i_bus_ready;
  logic [3:0]  o_bus_nibble;
  logic        o_bus_strobe;
  logic        o_bus_is_cmd;
  logic        o_busy;
  logic        o_done;
  logic [19:0] o_loaded_pc;

  saturn_bus_pc_loader dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_clk_en    (i_clk_en),
    .i_phases    (i_phases),
    .i_load_pc   (i_load_pc),
    .i_pc        (i_pc),
    .i_bus_ready (i_bus_ready),
    .o_bus_nibble(o_bus_nibble),
    .o_bus_strobe(o_bus_strobe),
    .o_bus_is_cmd(o_bus_is_cmd),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_loaded_pc (o_loaded_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Captured bus traffic (first strobe ends up in the top nibble).
  logic [27:0] cap_nibs;
  logic [6:0]  cap_cmd;
  int          n_strobe;
  int          n_done;

  // Reference model: a sequence is a list of 7 bus items, walked one per emit slot.
  bit          m_active;
  int          m_idx;
  logic [19:0] m_pc;
  bit          m_pend;
  logic [19:0] m_pend_pc;
  logic        e_strobe, e_done, e_busy, e_cmd;
  logic [3:0]  e_nib;
  logic [19:0] e_loaded;

  typedef struct {
    logic [19:0] pc;
    logic [7:0]  stall;
    logic [27:0] nibs;
    logic [6:0]  cmds;
    int          slots;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] seq_item(input logic [19:0] pc, input int k);
    logic [19:0] sh;
    if (k == 0) return 4'h4;
    if (k == 6) return 4'h0;
    sh = pc >> (4 * (k - 1));
    return sh[3:0];
  endfunction

  task automatic model_reset();
    m_active = 0; m_idx = 0; m_pc = '0; m_pend = 0; m_pend_pc = '0;
    e_strobe = 0; e_done = 0; e_busy = 0; e_cmd = 0; e_nib = '0; e_loaded = '0;
  endtask

  task automatic model_step();
    e_strobe = 0;
    e_done   = 0;
    if (i_clk_en && i_phases[3] && i_load_pc) begin
      if (!m_active) begin
        m_active = 1; m_pc = i_pc; m_idx = 0;
      end else begin
        m_pend = 1; m_pend_pc = i_pc;
      end
    end else if (i_clk_en && i_phases[0] && i_bus_ready && m_active) begin
      e_strobe = 1;
      e_nib    = seq_item(m_pc, m_idx);
      e_cmd    = (m_idx == 0 || m_idx == 6);
      m_idx++;
      if (m_idx == 7) begin
        e_done   = 1;
        e_loaded = m_pc;
        if (m_pend) begin
          m_pc = m_pend_pc; m_pend = 0; m_idx = 0;
        end else begin
          m_active = 0;
        end
      end
    end
    e_busy = m_active || e_done;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
    check("model", {o_bus_strobe, o_done, o_busy, o_bus_is_cmd, o_bus_nibble, o_loaded_pc},
          {e_strobe, e_done, e_busy, e_cmd, e_nib, e_loaded});
    if (i_clk_en) i_phases = {i_phases[2:0], i_phases[3]};
    if (o_bus_strobe) begin
      cap_nibs = {cap_nibs[23:0], o_bus_nibble};
      cap_cmd  = {cap_cmd[5:0], o_bus_is_cmd};
      n_strobe++;
    end
    if (o_done) n_done++;
  endtask

  task automatic clear_caps();
    cap_nibs = '0; cap_cmd = '0; n_strobe = 0; n_done = 0;
  endtask

  task automatic go_accept();
    for (int t = 0; t < 8 && i_phases != 4'b1000; t++) tick();
  endtask

  task automatic request(input logic [19:0] pc);
    go_accept();
    i_load_pc = 1'b1;
    i_pc      = pc;
    tick();
    i_load_pc = 1'b0;
  endtask

  task automatic wait_strobes(input int n);
    for (int t = 0; t < 100 && n_strobe < n; t++) tick();
  endtask

  task automatic wait_dones(input int n);
    for (int t = 0; t < 200 && n_done < n; t++) tick();
  endtask

  // Issue one request and count emit slots (stalled ones included) until done.
  task automatic run_req(input logic [19:0] pc, input logic [7:0] stall, output int slots);
    int k;
    clear_caps();
    k = 0;
    slots = -1;
    request(pc);
    for (int t = 0; t < 200 && n_done == 0; t++) begin
      if (i_phases[0]) begin
        i_bus_ready = (k < 8) ? !stall[k] : 1'b1;
        k++;
      end else begin
        i_bus_ready = 1'b1;
      end
      tick();
      if (n_done != 0) slots = k;
    end
    i_bus_ready = 1'b1;
  endtask

  initial begin
    int slots;
    bit busy_dropped;
    logic [27:0] snap;

    vecs[0] = '{pc: 20'h12345, stall: 8'b0000_0000, nibs: 28'h4543210, cmds: 7'b1000001, slots: 7};
    vecs[1] = '{pc: 20'hABCDE, stall: 8'b0000_1010, nibs: 28'h4EDCBA0, cmds: 7'b1000001, slots: 9};
    vecs[2] = '{pc: 20'h00000, stall: 8'b0000_0000, nibs: 28'h4000000, cmds: 7'b1000001, slots: 7};
    vecs[3] = '{pc: 20'hFFFFF, stall: 8'b0100_0001, nibs: 28'h4FFFFF0, cmds: 7'b1000001, slots: 9};

    rst_n = 1'b0; i_clk_en = 1'b1; i_phases = 4'b0001; i_load_pc = 1'b0;
    i_pc = '0; i_bus_ready = 1'b1;
    model_reset();
    clear_caps();
    repeat (3) tick();
    check("reset_outputs", {o_bus_strobe, o_done, o_busy, o_bus_is_cmd, o_bus_nibble, o_loaded_pc}, 28'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Table-driven single reloads.
    for (int v = 0; v < 4; v++) begin
      run_req(vecs[v].pc, vecs[v].stall, slots);
      check("vec_strobes", n_strobe, 7);
      check("vec_nibbles", cap_nibs, vecs[v].nibs);
      check("vec_is_cmd", cap_cmd, vecs[v].cmds);
      check("vec_done_slot", slots, vecs[v].slots);
      check("vec_loaded_pc", o_loaded_pc, vecs[v].pc);
      check("vec_busy_at_done", o_busy, 1'b1);
      tick();
      check("vec_busy_after", o_busy, 1'b0);
      $display("vector %0d pc=%05h strobes=%0d slots=%0d", v, vecs[v].pc, n_strobe, slots);
    end

    // Two requests during the address phase: only the newest chains on.
    clear_caps();
    request(20'h00010);
    wait_strobes(2);
    request(20'hFFFFF);
    request(20'h0ABC0);
    busy_dropped = 0;
    for (int t = 0; t < 200 && n_done < 2; t++) begin
      tick();
      if (n_done < 2 && !o_busy) busy_dropped = 1;
    end
    check("chain_dones", n_done, 2);
    check("chain_strobes", n_strobe, 14);
    check("chain_second_nibbles", cap_nibs, 28'h40CBA00);
    check("chain_busy_dropped", busy_dropped, 1'b0);
    check("chain_loaded_pc", o_loaded_pc, 20'h0ABC0);
    $display("chain test strobes=%0d dones=%0d loaded=%05h", n_strobe, n_done, o_loaded_pc);
    repeat (2) tick();

    // Asynchronous reset after the third address strobe.
    clear_caps();
    request(20'h54321);
    wait_strobes(4);
    check("abort_reached_strobe4", n_strobe, 4);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_immediate", {o_busy, o_bus_strobe, o_bus_nibble}, 6'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    clear_caps();
    repeat (30) tick();
    check("abort_no_strobes", n_strobe, 0);
    check("abort_loaded_pc", o_loaded_pc, 20'h00000);
    run_req(20'h00001, 8'h00, slots);
    check("after_abort_nibbles", cap_nibs, 28'h4100000);
    check("after_abort_slots", slots, 7);
    check("after_abort_loaded", o_loaded_pc, 20'h00001);
    $display("reset abort test, follow-on loaded=%05h", o_loaded_pc);
    repeat (2) tick();

    // Clock-enable pause in the middle of the address phase.
    clear_caps();
    request(20'h13579);
    wait_strobes(3);
    tick();
    snap = {o_bus_strobe, o_done, o_busy, o_bus_is_cmd, o_bus_nibble, o_loaded_pc};
    check("pause_snapshot_busy", o_busy, 1'b1);
    i_clk_en = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      check("pause_hold", {o_bus_strobe, o_done, o_busy, o_bus_is_cmd, o_bus_nibble, o_loaded_pc}, snap);
    end
    i_clk_en = 1'b1;
    wait_dones(1);
    check("pause_strobes", n_strobe, 7);
    check("pause_nibbles", cap_nibs, 28'h4975310);
    check("pause_loaded", o_loaded_pc, 20'h13579);
    $display("clk_en pause test strobes=%0d loaded=%05h", n_strobe, o_loaded_pc);

    // Randomized traffic against the model.
    clear_caps();
    for (int t = 0; t < 3000; t++) begin
      i_clk_en    = ($urandom % 8) != 0;
      i_bus_ready = ($urandom % 4) != 0;
      i_load_pc   = ($urandom % 12) == 0;
      i_pc        = 20'($urandom);
      tick();
    end
    i_clk_en = 1'b1; i_bus_ready = 1'b1; i_load_pc = 1'b0;
    repeat (80) tick();
    check("random_drain_idle", o_busy, 1'b0);
    $display("random test strobes=%0d dones=%0d", n_strobe, n_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
